// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and defaults for the image data ROM arbiter
package dmem_arb_pkg;

  typedef enum logic {ARB_CPU, ARB_DMA} arb_state_t;

  localparam int REQ_CPU = 0;
  localparam int REQ_DMA = 1;

  localparam int DATA_W_DEFAULT     = 32;
  localparam int DEPTH_DEFAULT      = 8100;
  localparam int STARVE_MAX_DEFAULT = 4;

  function automatic logic [15:0] sat_inc16(input logic [15:0] val, input logic en);
    return (en && val != 16'hFFFF) ? val + 16'd1 : val;
  endfunction

endpackage

// File: rtl/dmem_arb_if.sv
// rtl/dmem_arb_if.sv - CPU, DMA and ROM signal bundle of the data ROM arbiter
interface dmem_arb_if #(
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic [31:0]       cpu_addr;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  logic              dma_req;
  logic [31:0]       dma_addr;
  logic              dma_gnt;
  logic              dma_rvalid;
  logic [DATA_W-1:0] dma_rdata;
  logic [31:0]       rom_addr;
  logic [DATA_W-1:0] rom_rd;
  logic              oob_err;

  modport slave (
    input  cpu_req, cpu_addr, dma_req, dma_addr, rom_rd,
    output cpu_gnt, cpu_rvalid, cpu_rdata, dma_gnt, dma_rvalid, dma_rdata, rom_addr, oob_err
  );

  modport master (
    output cpu_req, cpu_addr, dma_req, dma_addr, rom_rd,
    input  cpu_gnt, cpu_rvalid, cpu_rdata, dma_gnt, dma_rvalid, dma_rdata, rom_addr, oob_err
  );
endinterface

// File: rtl/dmem_arb_stats.sv
// rtl/dmem_arb_stats.sv - saturating grant/stall counters, used under DMEM_ARB_STATS_EN
module dmem_arb_stats
  import dmem_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_gnt,
  input  logic        dma_gnt,
  input  logic        cpu_stall,
  output logic [15:0] stat_cpu_gnt,
  output logic [15:0] stat_dma_gnt,
  output logic [15:0] stat_cpu_stall
);
  logic [15:0] cpu_gnt_cnt_q, cpu_gnt_cnt_d;
  logic [15:0] dma_gnt_cnt_q, dma_gnt_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    cpu_gnt_cnt_d = sat_inc16(cpu_gnt_cnt_q, cpu_gnt);
    dma_gnt_cnt_d = sat_inc16(dma_gnt_cnt_q, dma_gnt);
    stall_cnt_d   = sat_inc16(stall_cnt_q, cpu_stall);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_gnt_cnt_q <= '0;
      dma_gnt_cnt_q <= '0;
      stall_cnt_q   <= '0;
    end else begin
      cpu_gnt_cnt_q <= cpu_gnt_cnt_d;
      dma_gnt_cnt_q <= dma_gnt_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign stat_cpu_gnt   = cpu_gnt_cnt_q;
  assign stat_dma_gnt   = dma_gnt_cnt_q;
  assign stat_cpu_stall = stall_cnt_q;
endmodule

// File: rtl/dmem_rom_arbiter.sv
// rtl/dmem_rom_arbiter.sv - CPU-priority arbiter for the image data ROM with DMA starvation guard
// Optional statistics counters are built when DMEM_ARB_STATS_EN is defined.
module dmem_rom_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEFAULT,
  parameter int DEPTH      = DEPTH_DEFAULT,
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  dmem_arb_if.slave   bus
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0] stat_cpu_gnt,
  output logic [15:0] stat_dma_gnt,
  output logic [15:0] stat_cpu_stall
`endif
);
  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SMAX    = CW'(STARVE_MAX);
  localparam logic [CW-1:0] SMAX_M1 = CW'(STARVE_MAX - 1);

  arb_state_t        state_q, state_d;
  logic [CW-1:0]     starve_q, starve_d;
  logic              cpu_rvalid_q, cpu_rvalid_d;
  logic              dma_rvalid_q, dma_rvalid_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
  logic              oob_q, oob_d;
  logic              cpu_gnt, dma_gnt, oob;
  logic [31:0]       rom_addr;
  logic [DATA_W-1:0] rd_data;

  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    state_d = state_q;
    // A forced DMA slot falls back to the CPU if the DMA has already withdrawn.
    if (!rst) begin
      if (state_q == ARB_DMA && bus.dma_req) dma_gnt = 1'b1;
      else if (bus.cpu_req)                  cpu_gnt = 1'b1;
      else if (bus.dma_req)                  dma_gnt = 1'b1;
    end

    starve_d = starve_q;
    if (!bus.dma_req || dma_gnt) starve_d = '0;
    else if (starve_q != SMAX)   starve_d = starve_q + 1'b1;

    case (state_q)
      ARB_CPU: if (bus.dma_req && !dma_gnt && starve_q == SMAX_M1) state_d = ARB_DMA;
      ARB_DMA: state_d = ARB_CPU;
      default: state_d = ARB_CPU;
    endcase

    rom_addr = cpu_gnt ? bus.cpu_addr : (dma_gnt ? bus.dma_addr : 32'd0);
    oob      = (cpu_gnt || dma_gnt) && (rom_addr >= 32'(DEPTH));
    rd_data  = oob ? '0 : bus.rom_rd;

    cpu_rvalid_d = cpu_gnt;
    dma_rvalid_d = dma_gnt;
    cpu_rdata_d  = cpu_gnt ? rd_data : cpu_rdata_q;
    dma_rdata_d  = dma_gnt ? rd_data : dma_rdata_q;
    oob_d        = oob;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB_CPU;
      starve_q     <= '0;
      cpu_rvalid_q <= 1'b0;
      dma_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
      oob_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      dma_rvalid_q <= dma_rvalid_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
      oob_q        <= oob_d;
    end
  end

  assign bus.cpu_gnt    = cpu_gnt;
  assign bus.dma_gnt    = dma_gnt;
  assign bus.rom_addr   = rom_addr;
  assign bus.cpu_rvalid = cpu_rvalid_q;
  assign bus.dma_rvalid = dma_rvalid_q;
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.dma_rdata  = dma_rdata_q;
  assign bus.oob_err    = oob_q;

`ifdef DMEM_ARB_STATS_EN
  dmem_arb_stats u_stats (
    .clk            (clk),
    .rst            (rst),
    .cpu_gnt        (cpu_gnt),
    .dma_gnt        (dma_gnt),
    .cpu_stall      (bus.cpu_req && !cpu_gnt),
    .stat_cpu_gnt   (stat_cpu_gnt),
    .stat_dma_gnt   (stat_dma_gnt),
    .stat_cpu_stall (stat_cpu_stall)
  );
`endif
endmodule
